// File: rtl/inst_fetch_queue.sv
// Circular instruction queue between IF branch select/check and decode: 0-4 writes, 2 read lanes.
// Latency: write-to-read 1 cycle, no IF->decode bypass; count and valids come from registered pointers.
// Backpressure: FIFO_allowIn_o high only with 4 free slots and no flush; decode retires 0-2 per cycle.
// Ports: flush_i redirect; IF_* write group (lane k = bits of lane k); ID_acceptNum_i retire count;
//        FIFO_* two oldest entries (lane 0 = oldest), FIFO_count_o occupancy.
`ifndef ALL_CHECKPOINT_LEN
`define ALL_CHECKPOINT_LEN 8
`endif

module inst_fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int CKPT_W = `ALL_CHECKPOINT_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        IF_valid_i,
    input  logic [2:0]                  IF_instNum_i,
    input  logic [127:0]                IF_inst_p_i,
    input  logic [127:0]                IF_predDest_p_i,
    input  logic [3:0]                  IF_predTake_p_i,
    input  logic [4*CKPT_W-1:0]         IF_predInfo_p_i,
    input  logic [31:0]                 IF_instBasePC_i,
    input  logic                        IF_hasException_i,
    input  logic                        IF_isRefill_i,
    input  logic [4:0]                  IF_ExcCode_i,
    output logic                        FIFO_allowIn_o,
    input  logic [1:0]                  ID_acceptNum_i,
    output logic [1:0]                  FIFO_valid_o,
    output logic [63:0]                 FIFO_inst_p_o,
    output logic [63:0]                 FIFO_PC_p_o,
    output logic [63:0]                 FIFO_predDest_p_o,
    output logic [1:0]                  FIFO_predTake_p_o,
    output logic [1:0]                  FIFO_hasException_o,
    output logic [1:0]                  FIFO_isRefill_o,
    output logic [2*CKPT_W-1:0]         FIFO_predInfo_p_o,
    output logic [9:0]                  FIFO_ExcCode_p_o,
    output logic [$clog2(DEPTH):0]      FIFO_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]       inst_q     [DEPTH];
    logic [31:0]       pc_q       [DEPTH];
    logic [31:0]       pdest_q    [DEPTH];
    logic              ptake_q    [DEPTH];
    logic [CKPT_W-1:0] pinfo_q    [DEPTH];
    logic              exc_q      [DEPTH];
    logic              refill_q   [DEPTH];
    logic [4:0]        code_q     [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] count;
    logic [1:0]    acc_n, rd_n;
    logic          wr_en;

    // Pointers carry one extra wrap bit so full (count = DEPTH) and empty differ.
    assign count          = tail_q - head_q;
    assign FIFO_count_o   = count;
    assign FIFO_allowIn_o = (count <= PW'(DEPTH - 4)) && !flush_i;
    assign wr_en          = IF_valid_i && FIFO_allowIn_o &&
                            (IF_instNum_i != 3'd0) && (IF_instNum_i <= 3'd4);

    // An accept of 3 means "as many as there are lanes"; then clamp to occupancy.
    assign acc_n = (ID_acceptNum_i == 2'd3) ? 2'd2 : ID_acceptNum_i;
    assign rd_n  = (count < PW'(acc_n)) ? count[1:0] : acc_n;

    always_comb begin
        head_d = head_q + PW'(rd_n);
        tail_d = tail_q + (wr_en ? PW'(IF_instNum_i) : PW'(0));
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage survives flush; only the pointers are cleared there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]   <= '0;
                pc_q[i]     <= '0;
                pdest_q[i]  <= '0;
                ptake_q[i]  <= 1'b0;
                pinfo_q[i]  <= '0;
                exc_q[i]    <= 1'b0;
                refill_q[i] <= 1'b0;
                code_q[i]   <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < IF_instNum_i) begin
                    inst_q[tail_q[AW-1:0] + AW'(k)]   <= IF_inst_p_i[32*k +: 32];
                    pc_q[tail_q[AW-1:0] + AW'(k)]     <= IF_instBasePC_i + 32'(4 * k);
                    pdest_q[tail_q[AW-1:0] + AW'(k)]  <= IF_predDest_p_i[32*k +: 32];
                    ptake_q[tail_q[AW-1:0] + AW'(k)]  <= IF_predTake_p_i[k];
                    pinfo_q[tail_q[AW-1:0] + AW'(k)]  <= IF_predInfo_p_i[CKPT_W*k +: CKPT_W];
                    exc_q[tail_q[AW-1:0] + AW'(k)]    <= IF_hasException_i;
                    refill_q[tail_q[AW-1:0] + AW'(k)] <= IF_isRefill_i;
                    code_q[tail_q[AW-1:0] + AW'(k)]   <= IF_ExcCode_i;
                end
            end
        end
    end

    for (genvar j = 0; j < 2; j++) begin : g_lane
        logic [AW-1:0] ridx;
        assign ridx                                 = head_q[AW-1:0] + AW'(j);
        assign FIFO_valid_o[j]                      = count > PW'(j);
        assign FIFO_inst_p_o[32*j +: 32]            = inst_q[ridx];
        assign FIFO_PC_p_o[32*j +: 32]              = pc_q[ridx];
        assign FIFO_predDest_p_o[32*j +: 32]        = pdest_q[ridx];
        assign FIFO_predTake_p_o[j]                 = ptake_q[ridx];
        assign FIFO_predInfo_p_o[CKPT_W*j +: CKPT_W] = pinfo_q[ridx];
        assign FIFO_hasException_o[j]               = exc_q[ridx];
        assign FIFO_isRefill_o[j]                   = refill_q[ridx];
        assign FIFO_ExcCode_p_o[5*j +: 5]           = code_q[ridx];
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed groups, stream across wrap, flush, boundaries, async reset.
// Expected entries are queued when a write is accepted; a negedge monitor pops and compares retiring lanes.
// Decode acceptance is driven by the bench; occupancy expectations come from the bench's own count.
module tb_inst_fetch_queue;
    localparam int DEPTH  = 8;
    localparam int CKPT_W = 8;
    localparam int EW     = 96 + 1 + CKPT_W + 7;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   flush_i = 1'b0;
    logic                   IF_valid_i = 1'b0;
    logic [2:0]             IF_instNum_i = '0;
    logic [127:0]           IF_inst_p_i = '0;
    logic [127:0]           IF_predDest_p_i = '0;
    logic [3:0]             IF_predTake_p_i = '0;
    logic [4*CKPT_W-1:0]    IF_predInfo_p_i = '0;
    logic [31:0]            IF_instBasePC_i = '0;
    logic                   IF_hasException_i = 1'b0;
    logic                   IF_isRefill_i = 1'b0;
    logic [4:0]             IF_ExcCode_i = '0;
    logic                   FIFO_allowIn_o;
    logic [1:0]             ID_acceptNum_i = '0;
    logic [1:0]             FIFO_valid_o;
    logic [63:0]            FIFO_inst_p_o, FIFO_PC_p_o, FIFO_predDest_p_o;
    logic [1:0]             FIFO_predTake_p_o, FIFO_hasException_o, FIFO_isRefill_o;
    logic [2*CKPT_W-1:0]    FIFO_predInfo_p_o;
    logic [9:0]             FIFO_ExcCode_p_o;
    logic [3:0]             FIFO_count_o;

    inst_fetch_queue #(.DEPTH(DEPTH), .CKPT_W(CKPT_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .IF_valid_i(IF_valid_i), .IF_instNum_i(IF_instNum_i), .IF_inst_p_i(IF_inst_p_i),
        .IF_predDest_p_i(IF_predDest_p_i), .IF_predTake_p_i(IF_predTake_p_i),
        .IF_predInfo_p_i(IF_predInfo_p_i), .IF_instBasePC_i(IF_instBasePC_i),
        .IF_hasException_i(IF_hasException_i), .IF_isRefill_i(IF_isRefill_i),
        .IF_ExcCode_i(IF_ExcCode_i), .FIFO_allowIn_o(FIFO_allowIn_o),
        .ID_acceptNum_i(ID_acceptNum_i), .FIFO_valid_o(FIFO_valid_o),
        .FIFO_inst_p_o(FIFO_inst_p_o), .FIFO_PC_p_o(FIFO_PC_p_o),
        .FIFO_predDest_p_o(FIFO_predDest_p_o), .FIFO_predTake_p_o(FIFO_predTake_p_o),
        .FIFO_hasException_o(FIFO_hasException_o), .FIFO_isRefill_o(FIFO_isRefill_o),
        .FIFO_predInfo_p_o(FIFO_predInfo_p_o), .FIFO_ExcCode_p_o(FIFO_ExcCode_p_o),
        .FIFO_count_o(FIFO_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    bit last_acc = 1'b0;
    logic [EW-1:0] sb [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected-entry producer: mirrors only the externally visible acceptance rules.
    int m_acc, m_rd, m_wr;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0;
            sb.delete();
            last_acc = 1'b0;
        end else if (flush_i) begin
            m_cnt = 0;
            sb.delete();
            last_acc = 1'b0;
        end else begin
            m_acc = (ID_acceptNum_i == 2'd3) ? 2 : int'(ID_acceptNum_i);
            m_rd  = (m_acc < m_cnt) ? m_acc : m_cnt;
            m_wr  = 0;
            if (IF_valid_i && m_cnt <= DEPTH - 4 && IF_instNum_i >= 3'd1 && IF_instNum_i <= 3'd4) begin
                m_wr = int'(IF_instNum_i);
                for (int k = 0; k < m_wr; k++)
                    sb.push_back({IF_inst_p_i[32*k +: 32], IF_instBasePC_i + 32'(4 * k),
                                  IF_predDest_p_i[32*k +: 32], IF_predTake_p_i[k],
                                  IF_predInfo_p_i[CKPT_W*k +: CKPT_W], IF_hasException_i,
                                  IF_isRefill_i, IF_ExcCode_i});
            end
            last_acc = (m_wr != 0);
            m_cnt = m_cnt + m_wr - m_rd;
        end
    end

    // Monitor: status every cycle, and pop/compare each lane decode retires.
    int mon_acc, mon_rd;
    logic [EW-1:0] mon_exp, mon_act;
    always @(negedge clk) begin
        if (rst) begin
            chk("count", 128'(FIFO_count_o), 128'(m_cnt));
            chk("valid", 128'(FIFO_valid_o), 128'({m_cnt > 1, m_cnt > 0}));
            chk("allowIn", 128'(FIFO_allowIn_o), 128'(m_cnt <= DEPTH - 4 && !flush_i));
            mon_acc = (ID_acceptNum_i == 2'd3) ? 2 : int'(ID_acceptNum_i);
            mon_rd  = flush_i ? 0 : ((mon_acc < m_cnt) ? mon_acc : m_cnt);
            for (int j = 0; j < mon_rd; j++) begin
                mon_act = {FIFO_inst_p_o[32*j +: 32], FIFO_PC_p_o[32*j +: 32],
                           FIFO_predDest_p_o[32*j +: 32], FIFO_predTake_p_o[j],
                           FIFO_predInfo_p_o[CKPT_W*j +: CKPT_W], FIFO_hasException_o[j],
                           FIFO_isRefill_o[j], FIFO_ExcCode_p_o[5*j +: 5]};
                if (sb.size() == 0) begin
                    chk("sb_underflow", 128'(1), 128'(0));
                end else begin
                    mon_exp = sb.pop_front();
                    chk($sformatf("lane%0d_entry", j), 128'(mon_act), 128'(mon_exp));
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [2:0] n, input logic [31:0] base,
                       input logic [127:0] ins, input logic [1:0] acc, input logic fl,
                       input logic ex, input logic rf, input logic [4:0] ec);
        IF_valid_i        = v;
        IF_instNum_i      = n;
        IF_instBasePC_i   = base;
        IF_inst_p_i       = ins;
        IF_predDest_p_i   = ins ^ 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
        IF_predTake_p_i   = base[5:2];
        IF_predInfo_p_i   = {base[7:0] + 8'd3, base[7:0] + 8'd2, base[7:0] + 8'd1, base[7:0]};
        IF_hasException_i = ex;
        IF_isRefill_i     = rf;
        IF_ExcCode_i      = ec;
        ID_acceptNum_i    = acc;
        flush_i           = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] acc);
        cyc(1'b0, 3'd0, 32'h0, 128'h0, acc, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && m_cnt != 0; i++) idle(2'd2);
        chk("drain_count", 128'(FIFO_count_o), 128'(0));
        chk("drain_sb_empty", 128'(sb.size()), 128'(0));
    endtask

    logic [31:0] pc;
    int          max_cnt;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 128'(FIFO_count_o), 128'(0));
        chk("rst_valid", 128'(FIFO_valid_o), 128'(0));
        chk("rst_lane_data", 128'(FIFO_inst_p_o), 128'(0));
        rst = 1'b1;
        #1;
        chk("rst_allowIn", 128'(FIFO_allowIn_o), 128'(1));

        // Full group of 4 at the boot vector
        cyc(1'b1, 3'd4, 32'hBFC00000, {32'h44, 32'h33, 32'h22, 32'h11}, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t1_valid", 128'(FIFO_valid_o), 128'(2'b11));
        chk("t1_pc0", 128'(FIFO_PC_p_o[31:0]), 128'(32'hBFC00000));
        chk("t1_pc1", 128'(FIFO_PC_p_o[63:32]), 128'(32'hBFC00004));
        chk("t1_inst", 128'(FIFO_inst_p_o), 128'({32'h22, 32'h11}));
        chk("t1_count", 128'(FIFO_count_o), 128'(4));
        drain();

        // Count=1 with accept=2 retires only one
        cyc(1'b1, 3'd1, 32'h00001000, 128'h77, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t3_valid1", 128'(FIFO_valid_o), 128'(2'b01));
        idle(2'd2);
        chk("t3_count", 128'(FIFO_count_o), 128'(0));
        chk("t3_valid0", 128'(FIFO_valid_o), 128'(2'b00));

        // Write and flush together: nothing lands
        cyc(1'b1, 3'd4, 32'h00002000, {4{32'hDEADBEEF}}, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("t4_count", 128'(FIFO_count_o), 128'(0));
        chk("t4_valid", 128'(FIFO_valid_o), 128'(0));
        cyc(1'b1, 3'd1, 32'h00003000, 128'hCAFE, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t4_new_inst", 128'(FIFO_inst_p_o[31:0]), 128'(32'hCAFE));
        drain();

        // Group-wide exception copied into both entries; accept=3 acts as 2
        cyc(1'b1, 3'd2, 32'h00004000, {32'h0, 32'h0, 32'hB2, 32'hB1}, 2'd0, 1'b0, 1'b1, 1'b1, 5'h04);
        chk("t5_exc", 128'(FIFO_hasException_o), 128'(2'b11));
        chk("t5_refill", 128'(FIFO_isRefill_o), 128'(2'b11));
        chk("t5_code", 128'(FIFO_ExcCode_p_o), 128'(10'h084));
        chk("t5_pc", 128'(FIFO_PC_p_o), 128'({32'h00004004, 32'h00004000}));
        idle(2'd3);
        chk("t5_acc3_count", 128'(FIFO_count_o), 128'(0));

        // Illegal group sizes write nothing
        cyc(1'b1, 3'd5, 32'h00005000, 128'h1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 3'd0, 32'h00005000, 128'h1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("num_illegal_count", 128'(FIFO_count_o), 128'(0));

        // Stream of 3-groups with decode taking 2: count cycles 3,4,5,3,...
        pc = 32'h00008000;
        max_cnt = 0;
        for (int it = 0; it < 16; it++) begin
            cyc(1'b1, 3'd3, pc, {32'h0, pc + 32'd8, pc + 32'd4, pc}, 2'd2, 1'b0, 1'b0, 1'b0, 5'd0);
            if (last_acc) pc = pc + 32'd12;
            if (int'(FIFO_count_o) > max_cnt) max_cnt = int'(FIFO_count_o);
        end
        chk("stream_max_count", 128'(max_cnt), 128'(5));
        drain();

        // Full boundary: 4 + 3 = 7, allowIn low, further write rejected
        cyc(1'b1, 3'd4, 32'h0000A000, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 3'd3, 32'h0000A010, {32'h0, 32'hA6, 32'hA5, 32'hA4}, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("full_count7", 128'(FIFO_count_o), 128'(7));
        chk("full_allowIn", 128'(FIFO_allowIn_o), 128'(0));
        cyc(1'b1, 3'd4, 32'h0000B000, {4{32'hBAD}}, 2'd1, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("full_count6", 128'(FIFO_count_o), 128'(6));

        // Asynchronous reset mid-cycle at count=6
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", 128'(FIFO_count_o), 128'(0));
        chk("arst_valid", 128'(FIFO_valid_o), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_hold_count", 128'(FIFO_count_o), 128'(0));

        // Operation resumes after reset
        cyc(1'b1, 3'd2, 32'h0000C000, {32'h0, 32'h0, 32'hC1, 32'hC0}, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("post_rst_count", 128'(FIFO_count_o), 128'(2));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Circular instruction queue between the IF-stage branch select/check logic and decode. Each cycle it accepts a compressed group of 0–4 consecutive instructions, each carrying its prediction, checkpoint and exception attributes. It delivers the two oldest entries per cycle to decode, which retires 0–2 of them. A back-end flush empties it.

## Interface
- DEPTH, 8, entry count; power of two, ≥8
- CKPT_W, `ALL_CHECKPOINT_LEN, per-instruction checkpoint width
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  back-end redirect; empties queue
- IF_valid_i  in  1  write group present
- IF_instNum_i  in  3  instructions in group, 0–4
- IF_inst_p_i  in  128  instructions; lane k in bits [32k+31:32k]
- IF_predDest_p_i  in  128  per-lane predicted target
- IF_predTake_p_i  in  4  per-lane predicted taken
- IF_predInfo_p_i  in  4*CKPT_W  per-lane checkpoint
- IF_instBasePC_i  in  32  PC of lane 0
- IF_hasException_i, IF_isRefill_i  in  1 each  group-wide fetch exception
- IF_ExcCode_i  in  5  group-wide ExcCode
- FIFO_allowIn_o  out  1  queue can take a full 4-instruction group
- ID_acceptNum_i  in  2  entries decode consumes this cycle, 0–2
- FIFO_valid_o  out  2  lane valid; lane 0 = oldest
- FIFO_inst_p_o, FIFO_PC_p_o, FIFO_predDest_p_o  out  64 each  per-lane fields
- FIFO_predTake_p_o, FIFO_hasException_o, FIFO_isRefill_o  out  2 each
- FIFO_predInfo_p_o  out  2*CKPT_W
- FIFO_ExcCode_p_o  out  10
- FIFO_count_o  out  log2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH entries of {inst, PC, predDest, predTake, predInfo, hasException, isRefill, ExcCode}.
- Pointers: head and tail, each log2(DEPTH)+1 bits. count = tail − head, modulo 2^(log2(DEPTH)+1). Index = pointer[log2(DEPTH)−1:0], so indices wrap naturally.
- FIFO_allowIn_o = (DEPTH − count ≥ 4) && !flush_i. The decision uses the registered count only; same-cycle reads are not credited.
- Write accept: IF_valid_i && FIFO_allowIn_o && 1 ≤ IF_instNum_i ≤ 4. Values 5–7 write nothing.
- On accept, lane k < IF_instNum_i goes to entry tail+k. Entry PC = IF_instBasePC_i + 4k (32-bit wrap). The exception fields are copied into every written entry. tail advances by IF_instNum_i.
- Read lanes: lane j shows entry head+j. FIFO_valid_o[j] = count > j. Output data is driven combinationally from storage. Data on an invalid lane is don't-care, but must not be X after reset.
- Read retire: rd = min(ID_acceptNum_i, count, 2). ID_acceptNum_i = 3 is treated as 2. head advances by rd.
- Simultaneous read and write: both pointers update on the same edge. A write never targets an entry being read, because the 4-free-slot margin guarantees it.
- Flush: on the next edge head = tail = 0. Any write or read in that cycle is discarded. Flush has priority over everything.
- Stored data is not cleared on flush; only the pointers are.

## Timing
- Reset (rst low, asynchronous): head = tail = 0, FIFO_count_o = 0, FIFO_valid_o = 2'b00, FIFO_allowIn_o = 1 once rst deasserts with flush_i low. Storage is reset to 0.
- Write-to-read latency is 1 cycle. An entry written at edge N is visible on lane 0 after edge N if the queue was empty. There is no bypass from IF inputs to decode outputs.
- FIFO_count_o is the registered count and updates one edge after each accept or retire.
- Full boundary: count = DEPTH−3 to DEPTH−1 forces allowIn low. Count never exceeds DEPTH.
- Empty boundary: count = 0 gives valid = 00 and rd = 0. Count = 1 gives valid = 01, and rd is clamped to 1.
- Reset mid-operation clears state immediately, with no dependence on the clock.

## Test plan
- Reset, then write group with instNum=4, base 0xBFC00000, insts 0x11..0x44 -> next cycle valid=11, lane PCs 0xBFC00000/0xBFC00004, count=4.
- Decode accepts 2 per cycle while IF writes 3-instruction groups continuously -> count rises; allowIn drops at count=5 (DEPTH=8); every instruction appears exactly once, in PC order across pointer wrap.
- Count=1 with ID_acceptNum_i=2 -> only 1 entry retires; count=0 next cycle, valid=00.
- Write and flush in the same cycle -> next cycle count=0, valid=00, written data never appears on the outputs.
- Write group instNum=2 with hasException=1, ExcCode=5'h04, isRefill=1 -> both entries show hasException=1, ExcCode=4, isRefill=1, and PCs base and base+4.
- Assert rst low mid-stream at count=6 -> count=0 and valid=00 asynchronously, before the next edge.
